// File: rtl/fpu_thread_issue_mux_pkg.sv
// Shared types and constants for the two-thread FP issue mux.
package fpu_thread_pkg;
  typedef logic tid_t;
  typedef enum logic {DS_IDLE = 1'b0, DS_BUSY = 1'b1} ds_state_t;
  localparam int E1         = 0;
  localparam int E2         = 1;
  localparam int E3         = 2;
  localparam int W          = 3;
  localparam int FPU_NSTAGE = 4;
endpackage

// File: rtl/fpu_thread_issue_mux_if.sv
// ID-side request/flush bundle and FPU-side stage status for the issue mux.
interface fpu_thread_issue_mux_if;
  logic req0, req1, hold0, hold1, ds0, ds1, flush0, flush1, ds_done;
  logic grant0, grant1, issue_v;
  logic e1v, e2v, e3v, wv;
  logic e1t, e2t, e3t, wt;
  logic dt, ds_busy;

  modport master (
    output req0, req1, hold0, hold1, ds0, ds1, flush0, flush1, ds_done,
    input  grant0, grant1, issue_v, e1v, e2v, e3v, wv, e1t, e2t, e3t, wt, dt, ds_busy
  );
  modport slave (
    input  req0, req1, hold0, hold1, ds0, ds1, flush0, flush1, ds_done,
    output grant0, grant1, issue_v, e1v, e2v, e3v, wv, e1t, e2t, e3t, wt, dt, ds_busy
  );
endinterface

// File: rtl/fpu_thread_issue_mux_arb.sv
// Two-requester round-robin arbiter; the thread just granted loses priority.
module fpu_rr_arb2
  import fpu_thread_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic clk,
  input  logic clrn,
  input  logic elig0,
  input  logic elig1,
  output logic grant0,
  output logic grant1
);
  tid_t prio;

  always_comb begin
    grant0 = elig0 & (~elig1 | (prio == 1'b0));
    grant1 = elig1 & ~grant0;
  end

  always_ff @(posedge clk) begin
    if (!clrn)       prio <= RR_INIT;
    else if (grant0) prio <= 1'b1;
    else if (grant1) prio <= 1'b0;
  end
endmodule

// File: rtl/fpu_thread_issue_mux.sv
// Two-thread FP issue mux: arbitration, per-stage thread tags/valids, flush masking, div/sqrt ownership.
module fpu_thread_issue_mux
  import fpu_thread_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input logic                   clk,
  input logic                   clrn,
  fpu_thread_issue_mux_if.slave bus
);
  logic                  elig0, elig1, g0, g1, issue, ds_busy;
  logic                  ds_grant;
  logic [1:0]            flush;
  logic [FPU_NSTAGE-1:0] sv, st;
  ds_state_t             ds_state;
  tid_t                  dt_q;

  assign ds_busy = (ds_state == DS_BUSY);
  assign flush   = {bus.flush1, bus.flush0};

  // Grants are suppressed while in reset so nothing is handed to the FPU then.
  assign elig0 = clrn & bus.req0 & ~bus.hold0 & ~bus.flush0 & ~(bus.ds0 & ds_busy);
  assign elig1 = clrn & bus.req1 & ~bus.hold1 & ~bus.flush1 & ~(bus.ds1 & ds_busy);

  fpu_rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk    (clk),
    .clrn   (clrn),
    .elig0  (elig0),
    .elig1  (elig1),
    .grant0 (g0),
    .grant1 (g1)
  );

  assign issue    = g0 | g1;
  assign ds_grant = (g0 & bus.ds0) | (g1 & bus.ds1);

  always_ff @(posedge clk) begin
    if (!clrn) begin
      sv       <= '0;
      st       <= '0;
      ds_state <= DS_IDLE;
      dt_q     <= 1'b0;
    end else begin
      sv[E1] <= issue;
      st[E1] <= g1;
      // Flush kills only the ops leaving E1 and E2; tags ride along unchanged.
      sv[E2] <= sv[E1] & ~flush[st[E1]];
      st[E2] <= st[E1];
      sv[E3] <= sv[E2] & ~flush[st[E2]];
      st[E3] <= st[E2];
      sv[W]  <= sv[E3];
      st[W]  <= st[E3];
      case (ds_state)
        DS_IDLE: if (ds_grant) begin
          ds_state <= DS_BUSY;
          dt_q     <= g1;
        end
        DS_BUSY: if (bus.ds_done) ds_state <= DS_IDLE;
        default: ds_state <= DS_IDLE;
      endcase
    end
  end

  assign bus.grant0  = g0;
  assign bus.grant1  = g1;
  assign bus.issue_v = issue;
  assign bus.e1v     = sv[E1];
  assign bus.e2v     = sv[E2];
  assign bus.e3v     = sv[E3];
  assign bus.wv      = sv[W];
  assign bus.e1t     = st[E1];
  assign bus.e2t     = st[E2];
  assign bus.e3t     = st[E3];
  assign bus.wt      = st[W];
  assign bus.dt      = dt_q;
  assign bus.ds_busy = ds_busy;
endmodule

// File: tb/tb_fpu_thread_issue_mux.sv
// Scoreboard bench: an op-list reference model predicts each cycle, a negedge monitor compares.
module tb_fpu_thread_issue_mux;
  localparam bit RR = 1'b1;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  always #5 clk = ~clk;

  fpu_thread_issue_mux_if ifc();

  fpu_thread_issue_mux #(.RR_INIT(RR)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (ifc)
  );

  typedef struct {
    bit       g0, g1;
    bit [3:0] v, t;
    bit       busy, dt;
  } exp_t;

  typedef struct {
    bit tid;
    int age;
    bit alive;
  } op_t;

  exp_t sb[$];
  op_t  ops[$];
  bit   m_prio = RR, m_busy = 1'b0, m_dt = 1'b0;
  int   total = 0, bad = 0;

  initial begin
    ifc.req0 = 0; ifc.req1 = 0; ifc.hold0 = 0; ifc.hold1 = 0;
    ifc.ds0 = 0; ifc.ds1 = 0; ifc.flush0 = 0; ifc.flush1 = 0; ifc.ds_done = 0;
  end

  // One cycle: drive inputs, predict this cycle's outputs, then advance the model past the edge.
  task automatic cyc(input bit rn, r0, r1, h0, h1, d0, d1, f0, f1, dn);
    exp_t e;
    bit el0, el1;
    @(posedge clk); #1;
    clrn = rn;
    ifc.req0 = r0; ifc.req1 = r1; ifc.hold0 = h0; ifc.hold1 = h1;
    ifc.ds0 = d0; ifc.ds1 = d1; ifc.flush0 = f0; ifc.flush1 = f1; ifc.ds_done = dn;
    e.v = '0; e.t = '0;
    foreach (ops[k]) if (ops[k].age >= 1 && ops[k].age <= 4) begin
      e.v[ops[k].age-1] = ops[k].alive;
      e.t[ops[k].age-1] = ops[k].tid;
    end
    el0 = rn & r0 & ~h0 & ~f0 & ~(d0 & m_busy);
    el1 = rn & r1 & ~h1 & ~f1 & ~(d1 & m_busy);
    if (el0 && el1) begin e.g0 = (m_prio == 0); e.g1 = (m_prio == 1); end
    else begin e.g0 = el0; e.g1 = el1; end
    e.busy = m_busy; e.dt = m_dt;
    sb.push_back(e);
    if (!rn) begin
      ops.delete(); m_prio = RR; m_busy = 0; m_dt = 0;
    end else begin
      foreach (ops[k]) begin
        if ((ops[k].age == 1 || ops[k].age == 2) && (ops[k].tid ? f1 : f0)) ops[k].alive = 0;
        ops[k].age++;
      end
      for (int k = ops.size() - 1; k >= 0; k--) if (ops[k].age > 4) ops.delete(k);
      if (e.g0 || e.g1) begin
        op_t n;
        n.tid = e.g1; n.age = 1; n.alive = 1;
        ops.push_back(n);
        m_prio = e.g0;
      end
      if (m_busy) begin
        if (dn) m_busy = 0;
      end else if ((e.g0 && d0) || (e.g1 && d1)) begin
        m_busy = 1; m_dt = e.g1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      bit [3:0] av, at;
      e = sb.pop_front();
      av = {ifc.wv, ifc.e3v, ifc.e2v, ifc.e1v};
      at = {ifc.wt, ifc.e3t, ifc.e2t, ifc.e1t};
      total++;
      if ({ifc.grant0, ifc.grant1, ifc.issue_v} !== {e.g0, e.g1, e.g0 | e.g1}) begin
        bad++;
        $display("FAIL grant t=%0t got g0/g1/iv=%b%b%b want %b%b%b", $time,
                 ifc.grant0, ifc.grant1, ifc.issue_v, e.g0, e.g1, e.g0 | e.g1);
      end
      total++;
      if (av !== e.v) begin
        bad++;
        $display("FAIL valids t=%0t got w,e3,e2,e1=%b want %b", $time, av, e.v);
      end
      total++;
      if (at !== e.t) begin
        bad++;
        $display("FAIL tags t=%0t got w,e3,e2,e1=%b want %b", $time, at, e.t);
      end
      total++;
      if ({ifc.ds_busy, ifc.dt} !== {e.busy, e.dt}) begin
        bad++;
        $display("FAIL ds t=%0t got busy/dt=%b%b want %b%b", $time,
                 ifc.ds_busy, ifc.dt, e.busy, e.dt);
      end
    end
  end

  initial begin
    // reset with both requesting: no grants, everything zero
    repeat (2) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // contention: alternation starting from the reset priority thread
    repeat (8) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // hold on thread 0, then release
    repeat (3) cyc(1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // div/sqrt ownership and blocking
    cyc(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    // flush: t1 in E3, t0 in E2/E1, flush0 for one cycle
    cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mid-operation reset while busy with all stages live
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 0, 0, 1, 1, 0, 0, 0);
    repeat (4) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    // ds_done while idle is ignored
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // randomized traffic
    repeat (600) cyc($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0,
                     $urandom_range(3) == 0, $urandom_range(3) == 0,
                     $urandom_range(3) == 0, $urandom_range(3) == 0,
                     $urandom_range(7) == 0, $urandom_range(7) == 0,
                     $urandom_range(5) == 0);
    @(posedge clk);
    @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
